// File: rtl/spi_reg_pkg.sv
// Shared constants, state encodings and frame payload type for the SPI register loader.
// Build option: SPI_PARITY_CHECK_EN adds a trailing even-parity bit to every frame.
package spi_reg_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DATA_W    = 5;
    localparam int unsigned PAYLOAD_W = ADDR_W + DATA_W;

`ifdef SPI_PARITY_CHECK_EN
    localparam int unsigned FRAME_BITS = PAYLOAD_W + 1;
`else
    localparam int unsigned FRAME_BITS = PAYLOAD_W;
`endif

    localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        I_IDLE,
        I_SHIFT,
        I_DONE
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE,
        O_HIGH,
        O_LOW
    } out_state_e;

    // One register write: first bit received lands in addr[2]
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } reg_frame_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Ports: clk, rst (async active-high), rst_val (level loaded on reset), d (async in), q (synced out).
// STAGES below 2 is raised to 2.
module sync_2ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {N{rst_val}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave that assembles {address[2:0], data[4:0]} frames and replays each
// as a stretched write_strobe pulse for signal_generator; one frame can wait in a pending slot.
// Ports: clk, rst (async active-high); sclk, cs_n, mosi (async SPI inputs);
//        write_strobe, address[2:0], data[4:0] (register write to signal_generator);
//        busy (strobe machine active or frame pending); overrun, parity_err (sticky flags).
// Build option: SPI_PARITY_CHECK_EN enables a 9th even-parity bit and the parity_err flag.
module spi_reg_loader
    import spi_reg_pkg::*;
#(
    parameter int unsigned STROBE_HOLD = 50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       write_strobe,
    output logic [2:0] address,
    output logic [4:0] data,
    output logic       busy,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned HOLD_W = $clog2(STROBE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STROBE_HOLD - 1);

    // Synchronizers, reset to the idle bus levels
    logic sclk_s, cs_n_s, mosi_s;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .rst_val(1'b0), .d(sclk), .q(sclk_s)
    );
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clk(clk), .rst(rst), .rst_val(1'b1), .d(cs_n), .q(cs_n_s)
    );
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .rst_val(1'b0), .d(mosi), .q(mosi_s)
    );

    // Edge detection on the synchronized SPI controls
    logic sclk_prev_q, cs_n_prev_q;
    logic sclk_rise, cs_fall, cs_rise;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_n_s & cs_n_prev_q;
    assign cs_rise   = cs_n_s & ~cs_n_prev_q;

    // Input side state
    in_state_e              in_state_q, in_state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic                   frame_done_q, frame_done_d;
    reg_frame_t             frame_q, frame_d;
`ifdef SPI_PARITY_CHECK_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // Output side state
    out_state_e             out_state_q, out_state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    reg_frame_t             out_frame_q, out_frame_d;
    reg_frame_t             pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   strobe_q, strobe_d;
    logic                   busy_q, busy_d;
    logic                   frame_taken;

    // Input FSM: frame assembly
    always_comb begin
        in_state_d   = in_state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        frame_d      = frame_q;
`ifdef SPI_PARITY_CHECK_EN
        parity_err_d = parity_err_q;
`endif
        case (in_state_q)
            I_IDLE: begin
                if (cs_fall) begin
                    in_state_d = I_SHIFT;
                    bit_cnt_d  = '0;
                end
            end
            I_SHIFT: begin
                if (cs_rise) begin
                    // Short frame is discarded
                    in_state_d = I_IDLE;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_d == BIT_CNT_W'(FRAME_BITS)) begin
                        in_state_d = I_DONE;
`ifdef SPI_PARITY_CHECK_EN
                        // Even parity: payload bits plus parity bit must XOR to 0
                        if (^shift_d) begin
                            parity_err_d = 1'b1;
                        end else begin
                            frame_done_d = 1'b1;
                            frame_d      = reg_frame_t'(shift_d[FRAME_BITS-1:1]);
                        end
`else
                        frame_done_d = 1'b1;
                        frame_d      = reg_frame_t'(shift_d);
`endif
                    end
                end
            end
            I_DONE: begin
                if (cs_rise) begin
                    in_state_d = I_IDLE;
                end
            end
            default: begin
                in_state_d = I_IDLE;
            end
        endcase
    end

    // Output FSM: strobe stretching and pending slot
    always_comb begin
        out_state_d  = out_state_q;
        hold_cnt_d   = hold_cnt_q;
        out_frame_d  = out_frame_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = overrun_q;
        frame_taken  = 1'b0;
        strobe_d     = (out_state_q == O_HIGH);
        busy_d       = (out_state_q != O_IDLE) || pend_valid_q;

        case (out_state_q)
            O_IDLE: begin
                if (frame_done_q) begin
                    out_frame_d = frame_q;
                    hold_cnt_d  = '0;
                    out_state_d = O_HIGH;
                    frame_taken = 1'b1;
                end
            end
            O_HIGH: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = '0;
                    out_state_d = O_LOW;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            O_LOW: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (pend_valid_q) begin
                        out_frame_d  = pend_q;
                        pend_valid_d = 1'b0;
                        out_state_d  = O_HIGH;
                    end else if (frame_done_q) begin
                        // Arrival on the closing cycle with nothing queued goes straight out
                        out_frame_d = frame_q;
                        out_state_d = O_HIGH;
                        frame_taken = 1'b1;
                    end else begin
                        out_state_d = O_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                out_state_d = O_IDLE;
                hold_cnt_d  = '0;
            end
        endcase

        // Frames arriving while busy: queue if the slot is (or just became) free
        if (frame_done_q && !frame_taken) begin
            if (!pend_valid_d) begin
                pend_d       = frame_q;
                pend_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_q  <= 1'b0;
            cs_n_prev_q  <= 1'b1;
            in_state_q   <= I_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_done_q <= 1'b0;
            frame_q      <= '0;
            out_state_q  <= O_IDLE;
            hold_cnt_q   <= '0;
            out_frame_q  <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sclk_prev_q  <= sclk_s;
            cs_n_prev_q  <= cs_n_s;
            in_state_q   <= in_state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
            frame_q      <= frame_d;
            out_state_q  <= out_state_d;
            hold_cnt_q   <= hold_cnt_d;
            out_frame_q  <= out_frame_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            strobe_q     <= strobe_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SPI_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign write_strobe = strobe_q;
    assign address      = out_frame_q.addr;
    assign data         = out_frame_q.data;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed bench for spi_reg_loader: table of single-frame transfers plus
// back-to-back overrun and mid-strobe reset sequences.
`timescale 1ns/1ps
module tb_spi_reg_loader;

`ifdef SPI_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int HOLD = 50;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    spi_reg_loader #(.STROBE_HOLD(HOLD), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .write_strobe(write_strobe), .address(address), .data(data),
        .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe monitor: logs every rising edge and run lengths of each phase
    int         rise_cnt = 0;
    logic [2:0] log_addr[$];
    logic [4:0] log_data[$];
    int         high_len[$];
    int         low_before[$];
    int         busy_fall_low = -1;
    int         run_len = 0;
    logic       strobe_prev = 1'b0;
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_low = run_len;
        if (write_strobe !== strobe_prev) begin
            if (write_strobe === 1'b1) begin
                rise_cnt++;
                log_addr.push_back(address);
                log_data.push_back(data);
                low_before.push_back(run_len);
            end else begin
                high_len.push_back(run_len);
            end
            run_len = 1;
        end else begin
            run_len++;
        end
        strobe_prev = write_strobe;
        busy_prev   = busy;
    end

    task automatic clear_log();
        @(posedge clk);
        rise_cnt = 0;
        log_addr.delete();
        log_data.delete();
        high_len.delete();
        low_before.delete();
        busy_fall_low = -1;
    endtask

    // Drive one cs_n window with n bits, MSB first; edges fall on multiples of 10 ns
    task automatic spi_send(input logic [15:0] bits, input int n, input int half);
        @(negedge clk);
        cs_n = 1'b0;
        #(half);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #(half);
            sclk = 1'b1;
            #(half);
            sclk = 1'b0;
        end
        #(half);
        cs_n = 1'b1;
        mosi = 1'b0;
        #(half);
    endtask

    task automatic send_full(input logic [7:0] payload, input logic bad_par,
                             input int extra, input int half);
        logic [15:0] bits;
        int          n;
        bits = {8'h00, payload};
        n    = 8;
        if (PAR) begin
            bits = {bits[14:0], (^payload) ^ bad_par};
            n++;
        end
        for (int k = 0; k < extra; k++) begin
            bits = {bits[14:0], 1'((k % 2) == 0)};
            n++;
        end
        spi_send(bits, n, half);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        repeat (5) @(negedge clk);
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({name, " idle"}, 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] payload;
        int         short_n;
        int         extra;
        logic       bad_par;
        int         exp_strobes;
        logic [2:0] exp_addr;
        logic [4:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        clear_log();
        if (v.short_n > 0) begin
            spi_send(16'(v.payload >> (8 - v.short_n)), v.short_n, 50);
        end else begin
            send_full(v.payload, v.bad_par, v.extra, 50);
        end
        wait_idle(nm, 3000);
        check({nm, " strobes"}, 32'(rise_cnt), 32'(v.exp_strobes));
        check({nm, " address"}, 32'(address), 32'(v.exp_addr));
        check({nm, " data"}, 32'(data), 32'(v.exp_data));
        check({nm, " parity_err"}, 32'(parity_err), 32'(v.exp_perr));
        if (v.exp_strobes == 1) begin
            check({nm, " high len"}, 32'(high_len.size() > 0 ? high_len[0] : -1), 32'(HOLD));
            check({nm, " low len"}, 32'(busy_fall_low), 32'(HOLD));
        end
    endtask

    initial begin
        // Expected decodes: payload[7:5] -> address, payload[4:0] -> data
        vecs.push_back('{8'hA5, 0, 0, 1'b0, 1, 3'd5, 5'd5,  1'b0});
        vecs.push_back('{8'hE0, 5, 0, 1'b0, 0, 3'd5, 5'd5,  1'b0});
        vecs.push_back('{8'h3F, 0, 0, 1'b0, 1, 3'd1, 5'd31, 1'b0});
        vecs.push_back('{8'hC7, 0, (PAR ? 3 : 4), 1'b0, 1, 3'd6, 5'd7, 1'b0});
        vecs.push_back('{8'h00, 0, 0, 1'b0, 1, 3'd0, 5'd0,  1'b0});
        vecs.push_back('{8'hFF, 0, 0, 1'b0, 1, 3'd7, 5'd31, 1'b0});
`ifdef SPI_PARITY_CHECK_EN
        vecs.push_back('{8'hA5, 0, 0, 1'b1, 0, 3'd7, 5'd31, 1'b1});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst strobe", 32'(write_strobe), 32'd0);
        check("rst address", 32'(address), 32'd0);
        check("rst data", 32'(data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Three frames back-to-back at clk = 4x sclk
        clear_log();
        check("b2b overrun before", 32'(overrun), 32'd0);
        send_full(8'h21, 1'b0, 0, 20);
        send_full(8'h46, 1'b0, 0, 20);
        send_full(8'h6B, 1'b0, 0, 20);
        wait_idle("b2b", 3000);
        check("b2b strobes", 32'(rise_cnt), 32'd2);
        check("b2b addr0", 32'(log_addr.size() > 0 ? log_addr[0] : 3'd0), 32'd1);
        check("b2b data0", 32'(log_data.size() > 0 ? log_data[0] : 5'd0), 32'd1);
        check("b2b addr1", 32'(log_addr.size() > 1 ? log_addr[1] : 3'd0), 32'd2);
        check("b2b data1", 32'(log_data.size() > 1 ? log_data[1] : 5'd0), 32'd6);
        check("b2b gap", 32'(low_before.size() > 1 ? low_before[1] : -1), 32'(HOLD));
        check("b2b high1", 32'(high_len.size() > 1 ? high_len[1] : -1), 32'(HOLD));
        check("b2b overrun", 32'(overrun), 32'd1);

        // Reset while the strobe is high
        clear_log();
        send_full(8'h99, 1'b0, 0, 50);
        repeat (10) @(negedge clk);
        check("pre-rst strobe", 32'(write_strobe), 32'd1);
        check("pre-rst address", 32'(address), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("mid-rst strobe", 32'(write_strobe), 32'd0);
        check("mid-rst address", 32'(address), 32'd0);
        check("mid-rst data", 32'(data), 32'd0);
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst overrun", 32'(overrun), 32'd0);
        check("mid-rst parity_err", 32'(parity_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_vec('{8'h5A, 0, 0, 1'b0, 1, 3'd2, 5'd26, 1'b0}, 99);
        check("post-rst overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
